// File: rtl/if_stage_pkg.sv
// Shared constants for the 16-bit five-stage pipeline: widths, opcodes and the bubble word.
package if_stage_pkg;

   localparam int WORD_W = 16;
   localparam int OFFS_W = 6;
   localparam int OPC_W  = 4;

   typedef enum logic [OPC_W-1:0] {
      OP_NOP  = 4'd0,
      OP_ADDI = 4'd9,
      OP_LD   = 4'd10,
      OP_ST   = 4'd11,
      OP_BZ   = 4'd12
   } opcode_e;

   localparam logic [WORD_W-1:0] NOP_WORD = {OP_NOP, 12'h000};

endpackage

// File: rtl/if_stage.sv
// Instruction fetch: PC, 1-cycle synchronous imem interface, branch redirect and a
// one-entry skid buffer that catches the in-flight response when decode stalls.
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC  = 16'h0000,
   parameter logic [WORD_W-1:0] NOP_INSTR = NOP_WORD
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     stall,
   input  logic                     branch_taken,
   input  logic signed [OFFS_W-1:0] branch_offset_imm,
   output logic                     imem_en,
   output logic [WORD_W-1:0]        imem_addr,
   input  logic [WORD_W-1:0]        imem_rdata,
   output logic [WORD_W-1:0]        if_id_instr,
   output logic [WORD_W-1:0]        if_id_pc,
   output logic                     if_id_valid
);

   logic [WORD_W-1:0] pc_q;
   logic [WORD_W-1:0] inflight_pc;
   logic              inflight_valid;
   logic [WORD_W-1:0] skid_instr;
   logic [WORD_W-1:0] skid_pc;
   logic              skid_valid;
   logic              skid_load;

   // Branch target is relative to the instruction after the branch.
   function automatic logic [WORD_W-1:0] branch_target(
      input logic [WORD_W-1:0]        base,
      input logic signed [OFFS_W-1:0] offs
   );
      logic signed [WORD_W-1:0] offs_ext;
      offs_ext = {{(WORD_W-OFFS_W){offs[OFFS_W-1]}}, offs};
      return base + WORD_W'(1) + $unsigned(offs_ext);
   endfunction

   assign imem_addr = pc_q;
   assign imem_en   = !stall && !branch_taken;
   assign skid_load = stall && inflight_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q           <= RESET_PC;
         inflight_valid <= 1'b0;
         inflight_pc    <= '0;
         skid_valid     <= 1'b0;
         if_id_instr    <= NOP_INSTR;
         if_id_pc       <= '0;
         if_id_valid    <= 1'b0;
      end else begin
         inflight_valid <= imem_en;
         if (imem_en) begin
            inflight_pc <= pc_q;
            pc_q        <= pc_q + WORD_W'(1);
         end

         if (stall) begin
            // Branch is ignored here; decode re-presents it once the stall clears.
            if (inflight_valid)
               skid_valid <= 1'b1;
         end else if (branch_taken) begin
            pc_q        <= branch_target(if_id_pc, branch_offset_imm);
            skid_valid  <= 1'b0;
            if_id_instr <= NOP_INSTR;
            if_id_pc    <= '0;
            if_id_valid <= 1'b0;
         end else if (skid_valid) begin
            if_id_instr <= skid_instr;
            if_id_pc    <= skid_pc;
            if_id_valid <= 1'b1;
            skid_valid  <= 1'b0;
         end else if (inflight_valid) begin
            if_id_instr <= imem_rdata;
            if_id_pc    <= inflight_pc;
            if_id_valid <= 1'b1;
         end else begin
            if_id_instr <= NOP_INSTR;
            if_id_pc    <= '0;
            if_id_valid <= 1'b0;
         end
      end
   end

   // Skid payload is qualified by skid_valid, so it carries no reset.
   always_ff @(posedge clk) begin
      if (skid_load) begin
         skid_instr <= imem_rdata;
         skid_pc    <= inflight_pc;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector tables, reset corner cases and a random run
// against an outstanding-fetch queue model, on two instances with different RESET_PC.
module tb_if_stage;

   localparam logic [15:0] PC_A = 16'h0000;
   localparam logic [15:0] PC_B = 16'hFFFE;

   typedef struct {
      bit          s;
      bit          b;
      logic [5:0]  o;
      bit          e_en;
      logic [15:0] e_addr;
      bit          e_v;
      logic [15:0] e_pc;
      logic [15:0] e_ins;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_v   [2];
   logic        br_v      [2];
   logic [5:0]  off_v     [2];
   logic        en_v      [2];
   logic [15:0] addr_v    [2];
   logic [15:0] rdata_v   [2];
   logic [15:0] ins_v     [2];
   logic [15:0] ipc_v     [2];
   logic        vld_v     [2];

   int          checks = 0;
   int          errors = 0;

   logic        cap_en    [2];
   logic [15:0] cap_addr  [2];

   logic [15:0] m_pc      [2];
   logic [15:0] m_ifpc    [2];
   logic [15:0] m_ins     [2];
   logic        m_vld     [2];
   logic [15:0] pend_a [$];
   logic [15:0] pend_b [$];

   vec_t ta [19];
   vec_t tb [8];

   always #5 clk = ~clk;

   if_stage #(.RESET_PC(PC_A), .NOP_INSTR(16'h0000)) dut_a (
      .clk(clk), .rst(rst), .stall(stall_v[0]), .branch_taken(br_v[0]),
      .branch_offset_imm(off_v[0]), .imem_en(en_v[0]), .imem_addr(addr_v[0]),
      .imem_rdata(rdata_v[0]), .if_id_instr(ins_v[0]), .if_id_pc(ipc_v[0]),
      .if_id_valid(vld_v[0])
   );

   if_stage #(.RESET_PC(PC_B), .NOP_INSTR(16'h0000)) dut_b (
      .clk(clk), .rst(rst), .stall(stall_v[1]), .branch_taken(br_v[1]),
      .branch_offset_imm(off_v[1]), .imem_en(en_v[1]), .imem_addr(addr_v[1]),
      .imem_rdata(rdata_v[1]), .if_id_instr(ins_v[1]), .if_id_pc(ipc_v[1]),
      .if_id_valid(vld_v[1])
   );

   // Synchronous ROM, mem[i] = 16'h1000 + i, one per instance.
   always @(posedge clk) begin
      if (en_v[0]) rdata_v[0] <= 16'h1000 + addr_v[0];
      if (en_v[1]) rdata_v[1] <= 16'h1000 + addr_v[1];
   end

   function automatic vec_t mkv(input bit s, input bit b, input logic [5:0] o,
                                input bit e_en, input logic [15:0] e_addr,
                                input bit e_v, input logic [15:0] e_pc, input logic [15:0] e_ins);
      vec_t v;
      v.s = s; v.b = b; v.o = o; v.e_en = e_en; v.e_addr = e_addr;
      v.e_v = e_v; v.e_pc = e_pc; v.e_ins = e_ins;
      return v;
   endfunction

   function automatic logic [15:0] rst_pc(input int k);
      return (k == 0) ? PC_A : PC_B;
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %h required %h", nm, act, exp);
      end
   endtask

   task automatic pend_clear(input int k);
      if (k == 0) pend_a.delete(); else pend_b.delete();
   endtask

   task automatic pend_push(input int k, input logic [15:0] v);
      if (k == 0) pend_a.push_back(v); else pend_b.push_back(v);
   endtask

   task automatic pend_pop(input int k, output bit have, output logic [15:0] head);
      have = 1'b0;
      head = '0;
      if (k == 0 && pend_a.size() > 0) begin have = 1'b1; head = pend_a.pop_front(); end
      if (k == 1 && pend_b.size() > 0) begin have = 1'b1; head = pend_b.pop_front(); end
   endtask

   task automatic bubble(input int k);
      m_vld[k] = 1'b0; m_ifpc[k] = '0; m_ins[k] = '0;
   endtask

   task automatic model_reset(input int k);
      m_pc[k] = rst_pc(k);
      pend_clear(k);
      bubble(k);
   endtask

   // One clock edge of the fetch stage, expressed as a queue of outstanding fetches.
   task automatic model_step(input int k);
      bit          have;
      logic [15:0] head;
      if (stall_v[k]) return;
      if (br_v[k]) begin
         pend_clear(k);
         m_pc[k] = 16'(int'(m_ifpc[k]) + 1 + int'($signed(off_v[k])));
         bubble(k);
         return;
      end
      pend_pop(k, have, head);
      if (have) begin
         m_vld[k] = 1'b1; m_ifpc[k] = head; m_ins[k] = 16'h1000 + head;
      end else begin
         bubble(k);
      end
      pend_push(k, m_pc[k]);
      m_pc[k] = m_pc[k] + 16'd1;
   endtask

   task automatic run_cycle(input bit s0, input bit b0, input logic [5:0] o0,
                            input bit s1, input bit b1, input logic [5:0] o1);
      stall_v[0] = s0; br_v[0] = b0; off_v[0] = o0;
      stall_v[1] = s1; br_v[1] = b1; off_v[1] = o1;
      #1;
      for (int k = 0; k < 2; k++) begin
         cap_en[k]   = en_v[k];
         cap_addr[k] = addr_v[k];
         chk($sformatf("imem_en[%0d]", k), en_v[k], !stall_v[k] && !br_v[k]);
         chk($sformatf("imem_addr[%0d]", k), addr_v[k], m_pc[k]);
         model_step(k);
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("valid[%0d]", k), vld_v[k], m_vld[k]);
         chk($sformatf("pc[%0d]", k), ipc_v[k], m_ifpc[k]);
         chk($sformatf("instr[%0d]", k), ins_v[k], m_ins[k]);
      end
   endtask

   task automatic chk_vec(input string tag, input int k, input int i, input vec_t v);
      chk($sformatf("%s[%0d].en", tag, i), cap_en[k], v.e_en);
      chk($sformatf("%s[%0d].addr", tag, i), cap_addr[k], v.e_addr);
      chk($sformatf("%s[%0d].valid", tag, i), vld_v[k], v.e_v);
      chk($sformatf("%s[%0d].pc", tag, i), ipc_v[k], v.e_pc);
      chk($sformatf("%s[%0d].instr", tag, i), ins_v[k], v.e_ins);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      // Instance A: straight line, stall with skid, stall+branch, forward and backward branch.
      ta[0]  = mkv(0, 0, 6'd0,  1, 16'd0,  0, 16'd0,  16'h0000);
      ta[1]  = mkv(0, 0, 6'd0,  1, 16'd1,  1, 16'd0,  16'h1000);
      ta[2]  = mkv(0, 0, 6'd0,  1, 16'd2,  1, 16'd1,  16'h1001);
      ta[3]  = mkv(0, 0, 6'd0,  1, 16'd3,  1, 16'd2,  16'h1002);
      ta[4]  = mkv(0, 0, 6'd0,  1, 16'd4,  1, 16'd3,  16'h1003);
      ta[5]  = mkv(0, 0, 6'd0,  1, 16'd5,  1, 16'd4,  16'h1004);
      ta[6]  = mkv(1, 0, 6'd0,  0, 16'd6,  1, 16'd4,  16'h1004);
      ta[7]  = mkv(1, 0, 6'd0,  0, 16'd6,  1, 16'd4,  16'h1004);
      ta[8]  = mkv(1, 0, 6'd0,  0, 16'd6,  1, 16'd4,  16'h1004);
      ta[9]  = mkv(0, 0, 6'd0,  1, 16'd6,  1, 16'd5,  16'h1005);
      ta[10] = mkv(0, 0, 6'd0,  1, 16'd7,  1, 16'd6,  16'h1006);
      ta[11] = mkv(1, 1, 6'd5,  0, 16'd8,  1, 16'd6,  16'h1006);
      ta[12] = mkv(0, 1, 6'd5,  0, 16'd8,  0, 16'd0,  16'h0000);
      ta[13] = mkv(0, 0, 6'd0,  1, 16'd12, 0, 16'd0,  16'h0000);
      ta[14] = mkv(0, 0, 6'd0,  1, 16'd13, 1, 16'd12, 16'h100C);
      ta[15] = mkv(0, 0, 6'd0,  1, 16'd14, 1, 16'd13, 16'h100D);
      ta[16] = mkv(0, 1, 6'h3E, 0, 16'd15, 0, 16'd0,  16'h0000);
      ta[17] = mkv(0, 0, 6'd0,  1, 16'd12, 0, 16'd0,  16'h0000);
      ta[18] = mkv(0, 0, 6'd0,  1, 16'd13, 1, 16'd12, 16'h100C);
      // Instance B: wrap-around fetch and a backward branch across 16'hFFFF.
      tb[0]  = mkv(0, 0, 6'd0,  1, 16'hFFFE, 0, 16'h0000, 16'h0000);
      tb[1]  = mkv(0, 0, 6'd0,  1, 16'hFFFF, 1, 16'hFFFE, 16'h0FFE);
      tb[2]  = mkv(0, 1, 6'h3E, 0, 16'h0000, 0, 16'h0000, 16'h0000);
      tb[3]  = mkv(0, 0, 6'd0,  1, 16'hFFFD, 0, 16'h0000, 16'h0000);
      tb[4]  = mkv(0, 0, 6'd0,  1, 16'hFFFE, 1, 16'hFFFD, 16'h0FFD);
      tb[5]  = mkv(0, 0, 6'd0,  1, 16'hFFFF, 1, 16'hFFFE, 16'h0FFE);
      tb[6]  = mkv(0, 0, 6'd0,  1, 16'h0000, 1, 16'hFFFF, 16'h0FFF);
      tb[7]  = mkv(0, 0, 6'd0,  1, 16'h0001, 1, 16'h0000, 16'h1000);

      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         stall_v[k] = 1'b0; br_v[k] = 1'b0; off_v[k] = '0;
      end
      repeat (2) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         model_reset(k);
         chk($sformatf("reset.valid[%0d]", k), vld_v[k], 1'b0);
         chk($sformatf("reset.instr[%0d]", k), ins_v[k], 16'h0000);
         chk($sformatf("reset.pc[%0d]", k), ipc_v[k], 16'h0000);
         chk($sformatf("reset.addr[%0d]", k), addr_v[k], rst_pc(k));
      end
      rst = 1'b0;

      for (int i = 0; i < 19; i++) begin
         run_cycle(ta[i].s, ta[i].b, ta[i].o, 1'b1, 1'b0, 6'd0);
         chk_vec("tblA", 0, i, ta[i]);
      end
      for (int i = 0; i < 8; i++) begin
         run_cycle(1'b1, 1'b0, 6'd0, tb[i].s, tb[i].b, tb[i].o);
         chk_vec("tblB", 1, i, tb[i]);
      end

      // Both instances stalled with a skidded response, then reset between edges.
      run_cycle(1'b1, 1'b0, 6'd0, 1'b1, 1'b0, 6'd0);
      #2 rst = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("midrst.valid[%0d]", k), vld_v[k], 1'b0);
         chk($sformatf("midrst.instr[%0d]", k), ins_v[k], 16'h0000);
         chk($sformatf("midrst.addr[%0d]", k), addr_v[k], rst_pc(k));
         model_reset(k);
      end
      @(negedge clk);
      rst = 1'b0;
      run_cycle(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
      for (int k = 0; k < 2; k++)
         chk($sformatf("postrst.first_addr[%0d]", k), cap_addr[k], rst_pc(k));
      run_cycle(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("postrst.valid[%0d]", k), vld_v[k], 1'b1);
         chk($sformatf("postrst.pc[%0d]", k), ipc_v[k], rst_pc(k));
      end

      // Random stall/branch traffic against the queue model.
      for (int i = 0; i < 400; i++) begin
         bit         s0, b0, s1, b1;
         logic [5:0] o0, o1;
         s0 = ($urandom_range(0, 3) == 0);
         b0 = ($urandom_range(0, 6) == 0);
         s1 = ($urandom_range(0, 3) == 0);
         b1 = ($urandom_range(0, 6) == 0);
         o0 = 6'($urandom);
         o1 = 6'($urandom);
         run_cycle(s0, b0, o0, s1, b1, o1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 16-bit five-stage pipeline. It sits directly upstream of the decode stage.
- Holds the PC and issues word-addressed reads to a synchronous instruction memory with 1-cycle latency.
- Drives the IF/ID pipeline register: instruction, PC and valid.
- Consumes the decode stage's combinational branch_taken and 6-bit branch offset to redirect fetch and squash wrong-path instructions. Absorbs downstream stalls with a one-entry skid buffer.

Parameters:
- RESET_PC, 16'h0000, first fetch address after reset.
- NOP_INSTR, 16'h0000, bubble encoding inserted into IF/ID (opcode 0 = NOP).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hazard hold: freeze IF/ID and PC.
- branch_taken  in  1  decode-stage branch resolved taken (combinational from the instruction in ID).
- branch_offset_imm  in  6  signed word offset of the branch in ID.
- imem_en  out  1  read request this cycle.
- imem_addr  out  16  read word address.
- imem_rdata  in  16  data for the address requested in the previous cycle.
- if_id_instr  out  16  instruction to decode.
- if_id_pc  out  16  PC of if_id_instr.
- if_id_valid  out  1  1 = real fetched instruction; 0 = bubble.

Behaviour:
- Reset is applied asynchronously on rst high. Reset values:
  - pc_q = RESET_PC, inflight_valid = 0, inflight_pc = 0, skid_valid = 0.
  - if_id_instr = NOP_INSTR, if_id_pc = 0, if_id_valid = 0.
- Reset mid-operation drops all in-flight, skid and IF/ID contents.
- imem_addr = pc_q (combinational).
- imem_en = !stall && !branch_taken.
- Issue: when imem_en = 1, the next edge sets:
  - inflight_valid <= 1, inflight_pc <= pc_q, pc_q <= pc_q + 1 (mod 2^16).
  - Otherwise inflight_valid <= 0 and pc_q holds, except on redirect.
- Per-edge priority, highest first:
  1. stall = 1:
     - IF/ID registers and pc_q hold; branch_taken is ignored (decode re-evaluates it after the stall).
     - If inflight_valid = 1: skid_instr <= imem_rdata, skid_pc <= inflight_pc, skid_valid <= 1.
     - If skid_valid is already 1, no response can arrive because no issue occurs during a stall.
  2. branch_taken = 1 (no stall):
     - pc_q <= if_id_pc + 1 + sext(branch_offset_imm), 16-bit wrap.
     - inflight_valid <= 0; skid_valid <= 0.
     - IF/ID <= {NOP_INSTR, pc 0, valid 0}.
     - Any in-flight response is discarded.
  3. skid_valid = 1:
     - IF/ID <= {skid_instr, skid_pc, 1}; skid_valid <= 0.
     - A new fetch is issued the same cycle, so there is no bubble on stall release.
  4. inflight_valid = 1:
     - IF/ID <= {imem_rdata, inflight_pc, 1}.
  5. Otherwise:
     - IF/ID <= {NOP_INSTR, 0, 0}.
- Latency:
  - An address issued in cycle n appears on IF/ID after the edge ending cycle n+1.
  - Straight-line steady state is 1 instruction per cycle.
- Branch penalty:
  - Decode sees 2 bubble cycles after the branch cycle, then the target instruction.
  - The branch instruction itself is squashed by decode.
- PC arithmetic:
  - All PC values are unsigned 16-bit.
  - The offset is sign-extended from bit 5, giving a range of -32..+31 relative to PC+1.
  - Wrap-around at 16'hFFFF -> 16'h0000 is legal and silent.

Decomposition:
- Shared pipeline package holds:
  - Opcode constants (NOP=0, ADDI=9, LD=10, ST=11, BZ=12).
  - NOP_INSTR, the 16-bit word/PC width constant, and the offset width (6).
- No sub-module: PC, skid and IF/ID register fit in one block.
- The sign-extend/adder may be a local function.

Test Plan:
- Use a sync ROM model with mem[i] = 16'h1000 + i.
- Straight-line fetch:
  - Stimulus: release rst, hold stall = 0, branch_taken = 0.
  - Response: imem_addr 0,1,2,... one per cycle. if_id_valid rises 2 edges after release with instr 16'h1000, pc 0, then 16'h1001/pc 1, consecutive, with no gaps.
- Forward branch:
  - Stimulus: branch_taken = 1 with offset 6'd5 while if_id_pc = 3.
  - Response: imem_en = 0 that cycle; next imem_addr = 9. IF/ID shows 2 bubbles (valid 0, instr 0), then 16'h1009/pc 9.
- Backward branch with wrap:
  - Stimulus: RESET_PC = 16'hFFFE; branch at if_id_pc = 16'hFFFE with offset 6'h3E (-2).
  - Response: target 16'hFFFD. Straight-line fetch also wraps 16'hFFFF -> 16'h0000.
- Stall with skid:
  - Stimulus: stall = 1 for 3 cycles mid-stream while if_id_pc = 4.
  - Response: if_id holds pc 4; imem_en = 0; the response for pc 5 is skidded. On release the sequence is pc 5, then pc 6 on the following edge, with no duplicate, loss or bubble.
- Stall and branch together:
  - Stimulus: stall = 1 and branch_taken = 1 in the same cycle.
  - Response: no redirect, pc_q unchanged. After stall drops with branch_taken still 1, the redirect occurs and the skid is discarded.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously between edges during a stall with skid_valid = 1.
  - Response: outputs immediately read if_id_valid = 0, if_id_instr = 0, imem_addr = RESET_PC. The first fetch after release is RESET_PC.
